// File: rtl/input_buffer_logic.sv
// Router port ingress: collects a 4-byte packet (header, 2 payload, XOR checksum),
// hands good packets downstream as a parallel word and drops/counts bad ones.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_COLLECT | accepting bytes, idx counts 3..0
// ST_CHECK   | full packet held; verify checksum, wait for output_buffer_free
// ST_LOAD    | input_buffer_loaded strobe, packet_out captured downstream
module input_buffer_logic #(
  parameter int PKT_BYTES = 4,
  parameter int CNT_W     = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  serial_valid,
  input  logic [7:0]            serial_data,
  output logic                  serial_ready,
  input  logic                  output_buffer_free,
  output logic                  input_buffer_loaded,
  output logic [3:0][7:0]       packet_out,
  output logic                  checksum_error,
  output logic [CNT_W-1:0]      packet_count,
  output logic [CNT_W-1:0]      error_count
);

  localparam logic [1:0] IDX_FIRST = 2'(PKT_BYTES - 1);

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_CHECK,
    ST_LOAD
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [3:0][7:0]     pkt_q, pkt_d;
  logic                ready_q, ready_d;
  logic                loaded_q, loaded_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    pcnt_q, pcnt_d;
  logic [CNT_W-1:0]    ecnt_q, ecnt_d;
  logic                accept;
  logic                chk_bad;

  assign accept  = serial_valid && ready_q && (state_q == ST_COLLECT);
  assign chk_bad = pkt_q[0] != (pkt_q[3] ^ pkt_q[2] ^ pkt_q[1]);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pkt_d    = pkt_q;
    loaded_d = 1'b0;
    err_d    = 1'b0;
    pcnt_d   = pcnt_q;
    ecnt_d   = ecnt_q;
    case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          pkt_d[idx_q] = serial_data;
          idx_d        = idx_q - 2'd1;
          if (idx_q == 2'd0) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (chk_bad) begin
          err_d   = 1'b1;
          ecnt_d  = (&ecnt_q) ? ecnt_q : ecnt_q + 1'b1;
          idx_d   = IDX_FIRST;
          state_d = ST_COLLECT;
        end else if (output_buffer_free) begin
          loaded_d = 1'b1;
          pcnt_d   = (&pcnt_q) ? pcnt_q : pcnt_q + 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        idx_d   = IDX_FIRST;
        state_d = ST_COLLECT;
      end
      default: begin
        idx_d   = IDX_FIRST;
        state_d = ST_COLLECT;
      end
    endcase
    // ready is registered from the next state so it is a clean Moore output
    ready_d = (state_d == ST_COLLECT);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_COLLECT;
      idx_q    <= IDX_FIRST;
      pkt_q    <= '0;
      ready_q  <= 1'b0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
      pcnt_q   <= '0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pkt_q    <= pkt_d;
      ready_q  <= ready_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
      pcnt_q   <= pcnt_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign serial_ready        = ready_q;
  assign input_buffer_loaded = loaded_q;
  assign checksum_error      = err_q;
  assign packet_out          = pkt_q;
  assign packet_count        = pcnt_q;
  assign error_count         = ecnt_q;

endmodule

// File: tb/tb_input_buffer_logic.sv
// Bench for input_buffer_logic: directed and random packets checked cycle by cycle
// against a packet-level model (byte array, saturating counters, XOR rule).
module tb_input_buffer_logic;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            serial_valid;
  logic [7:0]      serial_data;
  logic            serial_ready;
  logic            output_buffer_free;
  logic            input_buffer_loaded;
  logic [3:0][7:0] packet_out;
  logic            checksum_error;
  logic [7:0]      packet_count;
  logic [7:0]      error_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_pkt [4];
  int         m_pc;
  int         m_ec;

  always #5 clock = ~clock;

  input_buffer_logic #(.PKT_BYTES(4), .CNT_W(8)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .serial_valid       (serial_valid),
    .serial_data        (serial_data),
    .serial_ready       (serial_ready),
    .output_buffer_free (output_buffer_free),
    .input_buffer_loaded(input_buffer_loaded),
    .packet_out         (packet_out),
    .checksum_error     (checksum_error),
    .packet_count       (packet_count),
    .error_count        (error_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word();
    return {m_pkt[3], m_pkt[2], m_pkt[1], m_pkt[0]};
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic do_reset();
    reset_n            = 1'b0;
    serial_valid       = 1'b0;
    serial_data        = 8'h00;
    output_buffer_free = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 4; i++) m_pkt[i] = 8'h00;
    m_pc = 0;
    m_ec = 0;
    check("rst_ready", 32'(serial_ready), 32'd0);
    check("rst_loaded", 32'(input_buffer_loaded), 32'd0);
    check("rst_err", 32'(checksum_error), 32'd0);
    check("rst_pkt", packet_out, 32'd0);
    check("rst_pcnt", 32'(packet_count), 32'd0);
    check("rst_ecnt", 32'(error_count), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("ready_after_rst", 32'(serial_ready), 32'd1);
  endtask

  // pos 0 is the first byte of the packet, which belongs in packet_out[3]
  task automatic send_byte(input logic [7:0] b, input int gap, input int pos);
    int n;
    serial_valid = 1'b0;
    repeat (gap) @(negedge clock);
    serial_valid = 1'b1;
    serial_data  = b;
    n = 0;
    while (!serial_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!serial_ready) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clock);
    serial_valid  = 1'b0;
    m_pkt[3-pos]  = b;
    check("byte_place", packet_out, model_word());
  endtask

  task automatic send_pkt(input logic [7:0] b3, input logic [7:0] b2, input logic [7:0] b1,
                          input logic [7:0] b0, input int maxgap, input int free_wait,
                          input bit hold);
    bit good;
    good = (b0 == (b3 ^ b2 ^ b1));
    output_buffer_free = (free_wait == 0);
    send_byte(b3, $urandom_range(0, maxgap), 0);
    send_byte(b2, $urandom_range(0, maxgap), 1);
    send_byte(b1, $urandom_range(0, maxgap), 2);
    send_byte(b0, $urandom_range(0, maxgap), 3);
    if (hold) begin
      serial_valid = 1'b1;
      serial_data  = ~b3;
    end
    check("chk_ready", 32'(serial_ready), 32'd0);
    check("chk_loaded", 32'(input_buffer_loaded), 32'd0);
    check("chk_err", 32'(checksum_error), 32'd0);
    if (good) begin
      for (int i = 0; i < free_wait; i++) begin
        @(negedge clock);
        check("bp_ready", 32'(serial_ready), 32'd0);
        check("bp_loaded", 32'(input_buffer_loaded), 32'd0);
        check("bp_pkt", packet_out, model_word());
      end
      output_buffer_free = 1'b1;
      @(negedge clock);
      m_pc = sat_inc(m_pc);
      check("load_strobe", 32'(input_buffer_loaded), 32'd1);
      check("load_err", 32'(checksum_error), 32'd0);
      check("load_ready", 32'(serial_ready), 32'd0);
      check("load_pkt", packet_out, {b3, b2, b1, b0});
      check("load_pcnt", 32'(packet_count), 32'(m_pc));
      @(negedge clock);
      serial_valid = 1'b0;
      check("post_load_strobe", 32'(input_buffer_loaded), 32'd0);
      check("post_load_ready", 32'(serial_ready), 32'd1);
      check("post_load_pkt", packet_out, model_word());
    end else begin
      output_buffer_free = 1'($urandom_range(0, 1));
      @(negedge clock);
      serial_valid = 1'b0;
      m_ec = sat_inc(m_ec);
      check("bad_err", 32'(checksum_error), 32'd1);
      check("bad_loaded", 32'(input_buffer_loaded), 32'd0);
      check("bad_ready", 32'(serial_ready), 32'd1);
      check("bad_ecnt", 32'(error_count), 32'(m_ec));
      check("bad_pcnt", 32'(packet_count), 32'(m_pc));
      @(negedge clock);
      check("post_bad_err", 32'(checksum_error), 32'd0);
      check("post_bad_loaded", 32'(input_buffer_loaded), 32'd0);
      check("post_bad_pkt", packet_out, model_word());
    end
  endtask

  initial begin
    logic [7:0] r3, r2, r1, r0;
    reset_n            = 1'b0;
    serial_valid       = 1'b0;
    serial_data        = 8'h00;
    output_buffer_free = 1'b0;
    repeat (2) @(negedge clock);
    do_reset();

    // good packet, back-to-back
    send_pkt(8'hA5, 8'h3C, 8'h0F, 8'h96, 0, 0, 1'b0);
    // bad checksum, then a good packet must still be delivered intact
    send_pkt(8'hA5, 8'h3C, 8'h0F, 8'h00, 0, 0, 1'b0);
    send_pkt(8'hA5, 8'h3C, 8'h0F, 8'h96, 0, 0, 1'b0);
    // backpressure for 5 cycles
    send_pkt(8'hA5, 8'h3C, 8'h0F, 8'h96, 0, 5, 1'b0);
    // gaps between bytes and valid held through CHECK/LOAD
    send_pkt(8'h12, 8'h34, 8'h56, 8'h12 ^ 8'h34 ^ 8'h56, 3, 0, 1'b1);
    send_pkt(8'h01, 8'h02, 8'h03, 8'h55, 2, 0, 1'b1);

    // reset mid-packet
    send_byte(8'h11, 0, 0);
    send_byte(8'h22, 0, 1);
    do_reset();
    send_pkt(8'hA5, 8'h3C, 8'h0F, 8'h96, 0, 0, 1'b0);

    // random traffic
    for (int k = 0; k < 40; k++) begin
      r3 = 8'($urandom);
      r2 = 8'($urandom);
      r1 = 8'($urandom);
      r0 = r3 ^ r2 ^ r1;
      if ($urandom_range(0, 9) < 3) r0 = r0 ^ 8'($urandom_range(1, 255));
      send_pkt(r3, r2, r1, r0, $urandom_range(0, 2), $urandom_range(0, 3),
               1'($urandom_range(0, 1)));
    end

    // error counter saturation
    do_reset();
    for (int k = 0; k < 260; k++) begin
      r3 = 8'($urandom);
      r2 = 8'($urandom);
      r1 = 8'($urandom);
      r0 = r3 ^ r2 ^ r1 ^ 8'($urandom_range(1, 255));
      send_pkt(r3, r2, r1, r0, 0, 0, 1'b0);
    end
    check("sat_ecnt", 32'(error_count), 32'hFF);
    check("sat_pcnt", 32'(packet_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_buffer_logic.md
# input_buffer_logic

Ingress stage of each router port. It accepts a byte stream under a valid/ready handshake and assembles four-byte packets: header, two payload bytes, then an XOR checksum. Each packet is checked before handover. A good packet goes to the output buffer stage as a parallel `[3:0][7:0]` word with a one-cycle `input_buffer_loaded` strobe; a bad packet is dropped and counted.

## Interface
- `PKT_BYTES`, 4: bytes per packet. Fixed; other values are unsupported.
- `CNT_W`, 8: width of the statistics counters.

Ports:
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  synchronous, active-low reset
- `serial_valid`  in  1  byte present on `serial_data`
- `serial_data`  in  8  incoming byte
- `serial_ready`  out  1  block can accept a byte this cycle
- `output_buffer_free`  in  1  downstream stage can take a new packet
- `input_buffer_loaded`  out  1  one-cycle strobe: `packet_out` is valid
- `packet_out`  out  [3:0][7:0]  assembled packet; first received byte in `[3]`
- `checksum_error`  out  1  one-cycle strobe: packet dropped
- `packet_count`  out  `CNT_W`  packets delivered, saturating
- `error_count`  out  `CNT_W`  packets dropped, saturating

## Operation
- **Handshake.** A byte is accepted on a rising edge where `serial_valid && serial_ready`.
- **Byte placement.** A 2-bit index starts at 3 and decrements on each accept. The byte is written to `packet_out[idx]`, so the first byte lands in `[3]` and the fourth in `[0]`. This matches the downstream serializer order, `[3]` first.
- **States:**
  - **COLLECT:** `serial_ready`=1. On the accept where idx==0, go to CHECK.
  - **CHECK:** `serial_ready`=0.
    - If `packet_out[0] != packet_out[3]^packet_out[2]^packet_out[1]`: pulse `checksum_error`, increment `error_count`, reset idx to 3, go to COLLECT.
    - Else, if `output_buffer_free`: go to LOAD.
    - Else: stay in CHECK and hold `packet_out`.
  - **LOAD:** `serial_ready`=0, `input_buffer_loaded`=1. Increment `packet_count` on entry. Reset idx to 3. Next state is COLLECT.
- **Output stability.** `packet_out` changes only on accepted bytes. It is therefore stable throughout CHECK and LOAD, and on the edge that ends LOAD, where the downstream stage captures it.
- **Strobes.** `input_buffer_loaded` and `checksum_error` are registered. Each is high for exactly one cycle per event, and they are never high together.
- **Counters.** Both counters are `CNT_W` bits and saturate at all-ones, holding there with no wrap.
- **Reset values:** `serial_ready`=0, `input_buffer_loaded`=0, `checksum_error`=0, `packet_out`=0, both counters 0, idx=3. First state after reset is COLLECT.
- **Reset mid-packet.** Any partially collected bytes are discarded and the next accepted byte goes to `[3]`.
- **Other boundary cases:**
  - `serial_valid` low while `serial_ready` is high: no accept, state held.
  - `serial_valid` high in CHECK or LOAD: ignored. The upstream source must hold the byte until it is accepted.
  - `output_buffer_free` toggling while in CHECK: only its value at the decision edge matters.

## Timing
- `serial_ready` is a registered, Moore-decoded output and is high in the cycle after reset deasserts.
- Bytes accepted on consecutive edges E1–E4: CHECK occupies the cycle after E4.
- Good packet with `output_buffer_free`=1 at E5: `input_buffer_loaded` is high in the cycle after E5, and `serial_ready` returns high in the cycle after E6.
- Bad packet: `checksum_error` is high in the cycle after E5, and `serial_ready` is high in that same cycle.
- Minimum packet period is 6 cycles for a good packet and 5 for a bad one.
- Each cycle that `output_buffer_free` is low adds one CHECK cycle.

## Test plan
- **Good packet.** Reset, then send A5,3C,0F,96 back-to-back with `output_buffer_free`=1. Required:
  - `packet_out`=`{A5,3C,0F,96}`, i.e. `[3]`=A5 … `[0]`=96;
  - `input_buffer_loaded` high exactly 2 cycles after the 4th accept;
  - `packet_count`=1;
  - `serial_ready` low for 2 cycles, then high.
- **Bad checksum.** Send A5,3C,0F,00. Required: `checksum_error` single pulse, `error_count`=1, no `input_buffer_loaded`. Then send a valid packet; it must be delivered intact.
- **Backpressure.** Send the good packet with `output_buffer_free`=0 for 5 cycles, then 1. Required: state stays CHECK, `packet_out` stable and `serial_ready`=0 throughout; `input_buffer_loaded` pulses once, one cycle after `output_buffer_free` rises.
- **Gaps and held valid.** Toggle `serial_valid` with gaps between bytes, and hold `serial_valid` high during CHECK and LOAD. Required: only 4 accepts per packet, bytes placed in correct order, no extra accepts.
- **Reset mid-packet.** Accept 11,22, assert `reset_n`=0 for 1 cycle, then send A5,3C,0F,96. Required: all outputs reset, and the delivered packet is `{A5,3C,0F,96}`.
- **Saturation.** Send 260 bad packets. Required: `error_count` holds at FF and does not wrap, and `packet_count` stays 0.
